// File: rtl/pin_test_pkg.sv
// Shared types and constants for the pin_test_gen bring-up pattern generator.
package pin_test_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_LOOP  = 2'd3
    } mode_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/pin_test_prescaler.sv
// Programmable prescaler: one-cycle tick every div+1 cycles, with a synchronous
// clear used to restart the period when the generator changes mode.
module pin_test_prescaler #(
    parameter int DIV_WIDTH = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    // ">=" rather than "==" so lowering div below cnt wraps immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt >= div) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + DIV_WIDTH'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/pin_test_gen.sv
// Board bring-up pattern generator: CONST / BLINK / WALK / LFSR loopback modes.
// Define PIN_TEST_IN_SYNC_EN to put a 2-flop synchroniser on pin_in.
//
//   mode_q     | meaning
//   MODE_CONST | pin_out follows const_val
//   MODE_BLINK | all pins toggle on each tick
//   MODE_WALK  | single one rotates left on each tick
//   MODE_LOOP  | LFSR pattern out, pin_in checked against it on each tick
module pin_test_gen
    import pin_test_pkg::*;
#(
    parameter int          CH_COUNT  = 8,
    parameter int          DIV_WIDTH = 25,
    parameter int          ERR_WIDTH = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [CH_COUNT-1:0]  const_val,
    input  logic                 clr_err,
    input  logic [CH_COUNT-1:0]  pin_in,
    output logic [CH_COUNT-1:0]  pin_out,
    output logic                 tick,
    output logic [ERR_WIDTH-1:0] err_cnt,
    output logic                 err_flag
);

    mode_t                mode_q, mode_nxt;
    logic                 mode_chg;
    logic [CH_COUNT-1:0]  walk, walk_rot, walk_nxt;
    logic [15:0]          lfsr, lfsr_nxt;
    logic                 loop_armed, armed_nxt;
    logic [CH_COUNT-1:0]  pin_out_nxt, pin_cmp;
    logic [ERR_WIDTH-1:0] err_cnt_nxt;
    logic                 err_flag_nxt, mismatch;

    pin_test_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (mode_chg),
        .div  (div),
        .tick (tick)
    );

`ifdef PIN_TEST_IN_SYNC_EN
    logic [CH_COUNT-1:0] pin_meta, pin_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_meta <= '0;
            pin_sync <= '0;
        end else begin
            pin_meta <= pin_in;
            pin_sync <= pin_meta;
        end
    end

    assign pin_cmp = pin_sync;
`else
    assign pin_cmp = pin_in;
`endif

    generate
        if (CH_COUNT == 1) begin : g_rot_single
            assign walk_rot = walk;
        end else begin : g_rot_multi
            assign walk_rot = {walk[CH_COUNT-2:0], walk[CH_COUNT-1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_q <= MODE_CONST;
        else     mode_q <= mode_nxt;
    end

    always_comb begin
        mode_nxt = mode_t'(mode);
        mode_chg = (mode_nxt != mode_q);
    end

    always_comb begin
        pin_out_nxt  = pin_out;
        walk_nxt     = walk;
        lfsr_nxt     = lfsr;
        armed_nxt    = loop_armed;
        mismatch     = 1'b0;
        err_cnt_nxt  = err_cnt;
        err_flag_nxt = err_flag;

        if (mode_chg) begin
            pin_out_nxt = '0;
            walk_nxt    = CH_COUNT'(1);
            lfsr_nxt    = LFSR_SEED;
            armed_nxt   = 1'b0;
        end else begin
            case (mode_q)
                MODE_CONST: pin_out_nxt = const_val;
                MODE_BLINK: if (tick) pin_out_nxt = ~pin_out;
                MODE_WALK: begin
                    if (tick) walk_nxt = walk_rot;
                    pin_out_nxt = tick ? walk_rot : walk;
                end
                MODE_LOOP: begin
                    if (tick) begin
                        mismatch    = loop_armed && (pin_cmp != pin_out);
                        lfsr_nxt    = lfsr_step(lfsr);
                        armed_nxt   = 1'b1;
                        pin_out_nxt = lfsr_nxt[CH_COUNT-1:0];
                    end else begin
                        pin_out_nxt = lfsr[CH_COUNT-1:0];
                    end
                end
                default: pin_out_nxt = '0;
            endcase
        end

        // Clear wins over a same-cycle mismatch.
        if (clr_err) begin
            err_cnt_nxt  = '0;
            err_flag_nxt = 1'b0;
        end else if (mismatch) begin
            if (err_cnt != '1) err_cnt_nxt = err_cnt + ERR_WIDTH'(1);
            err_flag_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_out    <= '0;
            walk       <= CH_COUNT'(1);
            lfsr       <= LFSR_SEED;
            loop_armed <= 1'b0;
            err_cnt    <= '0;
            err_flag   <= 1'b0;
        end else begin
            pin_out    <= pin_out_nxt;
            walk       <= walk_nxt;
            lfsr       <= lfsr_nxt;
            loop_armed <= armed_nxt;
            err_cnt    <= err_cnt_nxt;
            err_flag   <= err_flag_nxt;
        end
    end

endmodule

// File: tb/tb_pin_test_gen.sv
// Directed self-checking bench for pin_test_gen (main instance plus a 4-bit error counter instance).
module tb_pin_test_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [24:0] div;
    logic [7:0]  const_val, kill;
    logic        clr_err;
    logic [7:0]  pin_in, pin_out, pin_in2, pin_out2;
    logic        tick, tick2, err_flag, err_flag2;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt2;

    int          n_chk = 0;
    int          n_err = 0;
    int          cnt_t, exp_err;
    logic [15:0] mdl;
    logic        armed, found;

    always #5 clk = ~clk;

    assign pin_in  = pin_out & ~kill;
    assign pin_in2 = ~pin_out2;

    pin_test_gen dut (
        .clk(clk), .rst(rst), .mode(mode), .div(div), .const_val(const_val),
        .clr_err(clr_err), .pin_in(pin_in), .pin_out(pin_out), .tick(tick),
        .err_cnt(err_cnt), .err_flag(err_flag)
    );

    pin_test_gen #(.ERR_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .mode(mode), .div(div), .const_val(const_val),
        .clr_err(clr_err), .pin_in(pin_in2), .pin_out(pin_out2), .tick(tick2),
        .err_cnt(err_cnt2), .err_flag(err_flag2)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mode = 2'd1; div = 25'd3; const_val = 8'h00; kill = 8'h00; clr_err = 1'b0;
        step(2);
        chk_eq("rst_pin", 32'(pin_out), 32'h0);
        chk_eq("rst_tick", 32'(tick), 32'h0);
        chk_eq("rst_tick2", 32'(tick2), 32'h0);
        chk_eq("rst_err", 32'(err_cnt), 32'h0);
        chk_eq("rst_flag", 32'(err_flag), 32'h0);

        // BLINK, then asynchronous reset mid-run
        rst = 1'b0;
        step(6);
        chk_eq("blink_pre", 32'(pin_out), 32'hFF);
        #3 rst = 1'b1;
        #1;
        chk_eq("async_pin", 32'(pin_out), 32'h0);
        chk_eq("async_tick", 32'(tick), 32'h0);
        step(1);
        rst = 1'b0;
        step(4);
        chk_eq("blink_t0", 32'(tick), 32'h0);
        step(1);
        chk_eq("blink_t1", 32'(tick), 32'h1);
        chk_eq("blink_p0", 32'(pin_out), 32'h00);
        step(1);
        chk_eq("blink_p1", 32'(pin_out), 32'hFF);
        chk_eq("blink_t2", 32'(tick), 32'h0);
        step(3);
        chk_eq("blink_t3", 32'(tick), 32'h1);
        step(1);
        chk_eq("blink_p2", 32'(pin_out), 32'h00);

        // WALK, div=0, including wrap
        mode = 2'd2; div = 25'd0;
        step(1);
        chk_eq("walk_chg", 32'(pin_out), 32'h0);
        for (int i = 0; i < 9; i++) begin
            logic [7:0] e;
            e = 8'h01 << (i % 8);
            step(1);
            chk_eq("walk_seq", 32'(pin_out), 32'(e));
        end

        // CONST, then switch to WALK mid-count
        mode = 2'd0; const_val = 8'hA5; div = 25'd5;
        step(1);
        chk_eq("const_chg", 32'(pin_out), 32'h0);
        step(1);
        chk_eq("const_a5", 32'(pin_out), 32'hA5);
        const_val = 8'h3C;
        step(1);
        chk_eq("const_3c", 32'(pin_out), 32'h3C);
        step(2);
        mode = 2'd2;
        step(1);
        chk_eq("cw_pin0", 32'(pin_out), 32'h0);
        chk_eq("cw_tick0", 32'(tick), 32'h0);
        step(1);
        chk_eq("cw_pin1", 32'(pin_out), 32'h01);
        step(4);
        chk_eq("cw_tick_early", 32'(tick), 32'h0);
        step(1);
        chk_eq("cw_tick", 32'(tick), 32'h1);
        step(1);
        chk_eq("cw_pin2", 32'(pin_out), 32'h02);

        // LOOP with clean loopback, div=4
        mode = 2'd3; div = 25'd4;
        step(1);
        chk_eq("loop_chg", 32'(pin_out), 32'h0);
        step(1);
        chk_eq("loop_seed", 32'(pin_out), 32'hE1);
        step(4);
        chk_eq("loop_tick1", 32'(tick), 32'h1);
        step(1);
        chk_eq("loop_p1", 32'(pin_out), 32'h70);
        step(4);
        chk_eq("loop_tick2", 32'(tick), 32'h1);
        step(1);
        chk_eq("loop_p2", 32'(pin_out), 32'h38);
        chk_eq("loop_err2_first", 32'(err_cnt2), 32'h1);
        mdl = 16'h7138;
        cnt_t = 0;
        for (int c = 0; c < 2000 && cnt_t < 100; c++) begin
            step(1);
            if (tick) begin
                step(1);
                mdl = lfsr_adv(mdl);
                chk_eq("loop_seq", 32'(pin_out), 32'(mdl[7:0]));
                cnt_t++;
            end
        end
        chk_eq("loop_ticks", cnt_t, 100);
        chk_eq("loop_err", 32'(err_cnt), 32'h0);
        chk_eq("loop_flag", 32'(err_flag), 32'h0);
        chk_eq("sat_err2", 32'(err_cnt2), 32'hF);
        chk_eq("sat_flag2", 32'(err_flag2), 32'h1);

        // pin_in[3] stuck low
        kill = 8'h08; exp_err = 0; cnt_t = 0;
        for (int c = 0; c < 400 && cnt_t < 20; c++) begin
            step(1);
            if (tick) begin
                if (mdl[3]) exp_err++;
                step(1);
                mdl = lfsr_adv(mdl);
                cnt_t++;
            end
        end
        chk_eq("fault_ticks", cnt_t, 20);
        chk_eq("fault_err", 32'(err_cnt), exp_err);
        chk_eq("fault_flag", 32'(err_flag), 32'(exp_err != 0));

        // lowering div below the running count, in BLINK
        mode = 2'd1; div = 25'd20;
        step(1);
        chk_eq("dl_chg_tick", 32'(tick), 32'h0);
        step(10);
        chk_eq("dl_pre_tick", 32'(tick), 32'h0);
        div = 25'd2;
        step(1);
        chk_eq("dl_tick_a", 32'(tick), 32'h1);
        chk_eq("dl_pin_a", 32'(pin_out), 32'h00);
        step(1);
        chk_eq("dl_tick_b", 32'(tick), 32'h0);
        chk_eq("dl_pin_b", 32'(pin_out), 32'hFF);
        step(1);
        chk_eq("dl_tick_c", 32'(tick), 32'h0);
        step(1);
        chk_eq("dl_tick_d", 32'(tick), 32'h1);
        chk_eq("err_retained", 32'(err_cnt), exp_err);

        // clr_err coinciding with a mismatch
        mode = 2'd3; div = 25'd4;
        step(1);
        mdl = 16'hACE1; armed = 1'b0; found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            step(1);
            if (tick) begin
                if (armed && mdl[3]) begin
                    clr_err = 1'b1;
                    step(1);
                    clr_err = 1'b0;
                    found = 1'b1;
                    chk_eq("clr_prio_err", 32'(err_cnt), 32'h0);
                    chk_eq("clr_prio_flag", 32'(err_flag), 32'h0);
                end else begin
                    step(1);
                end
                armed = 1'b1;
                mdl = lfsr_adv(mdl);
            end
        end
        chk_eq("clr_found", 32'(found), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pin_test_gen.md
Name: pin_test_gen

Overview:
- Parametrised board bring-up pattern generator.
- Generalises a single free-running blink counter into CH_COUNT output channels with a programmable prescaler and four runtime modes: constant, blink, walking-one, and LFSR loopback with error checking.
- Sits in test/bring-up top levels between the on-chip oscillator and the header pins.
- Loopback wires on the board connect pin_out to pin_in.

Parameters:
- CH_COUNT, 8, number of output/input channels (1..16).
- DIV_WIDTH, 25, prescaler counter and div port width.
- ERR_WIDTH, 16, error counter width.
- LFSR_SEED, 16'hACE1, LFSR reset/entry value; must be non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode  in  2  0=CONST, 1=BLINK, 2=WALK, 3=LOOP
- div  in  DIV_WIDTH  tick period minus one
- const_val  in  CH_COUNT  pattern driven in CONST mode
- clr_err  in  1  synchronous clear of err_cnt/err_flag
- pin_in  in  CH_COUNT  loopback inputs
- pin_out  out  CH_COUNT  pattern outputs (registered)
- tick  out  1  one-cycle pulse per prescaler period
- err_cnt  out  ERR_WIDTH  saturating mismatch count
- err_flag  out  1  sticky mismatch indicator

Behaviour:
- Reset (async assert, sync-released use):
  - pin_out=0, tick=0, err_cnt=0, err_flag=0, prescaler count=0, walk reg=1, lfsr=LFSR_SEED, loop_armed=0, mode_q=0.
- Prescaler:
  - cnt increments each cycle.
  - When cnt >= div: cnt<=0 and tick<=1 next cycle; otherwise tick<=0.
  - div=0 gives tick every cycle.
  - div lowered below the current cnt wraps on the next cycle; no lockup.
- Mode change (mode != mode_q), applied that cycle:
  - cnt<=0, walk<=1, lfsr<=LFSR_SEED, loop_armed<=0, pin_out<=0, tick<=0.
  - mode_q<=mode.
  - err_cnt/err_flag retained.
- CONST: pin_out<=const_val every cycle (1-cycle latency, independent of tick).
- BLINK: on each tick event, pin_out<=~pin_out (all bits toggle together).
- WALK:
  - pin_out = walk[CH_COUNT-1:0] registered.
  - On tick, walk rotates left by one; bit CH_COUNT-1 wraps to bit 0.
  - CH_COUNT=1 stays at 1.
- LOOP:
  - 16-bit Galois LFSR, mask 16'hB400, shifts right.
  - pin_out = lfsr[CH_COUNT-1:0].
  - At each tick event, if loop_armed, compare the sampled input (pin_in, or its synchronised version) with the current pin_out.
  - Then advance the lfsr and set loop_armed<=1.
  - The first tick after entering LOOP is not compared.
  - Any bit mismatch: err_cnt<=err_cnt+1, saturating at all-ones; err_flag<=1.
- clr_err: takes priority over a same-cycle mismatch; err_cnt<=0, err_flag<=0.
- Board-level constraint, not checked in RTL: div+1 must exceed the loopback path latency.

Optional Feature:
- PIN_TEST_IN_SYNC_EN defined:
  - pin_in passes through a 2-flop synchroniser (reset 0) before comparison.
  - Compare latency is +2 cycles, so div >= 2 is required for valid LOOP results.
- Not defined: pin_in is compared directly. Use only for on-chip or clk-synchronous loopback.

Decomposition:
- Package pin_test_pkg:
  - typedef enum logic [1:0] mode_t {MODE_CONST, MODE_BLINK, MODE_WALK, MODE_LOOP}.
  - LFSR_MASK=16'hB400 constant.
- Sub-module pin_test_prescaler: cnt/div/tick, with a sync clear input driven by the mode change.

Test Plan:
- Reset mid-run in BLINK with div=3: assert rst asynchronously → all outputs 0 immediately. After release, tick pulses every 4 cycles; pin_out toggles 00→FF→00.
- WALK, CH_COUNT=8, div=0 → pin_out 01,02,04,...,80,01 on successive cycles after the first; wrap is verified.
- CONST const_val=A5 → pin_out=A5 one cycle later. Switch to WALK mid-count → pin_out=0 for one cycle, then 01, with cnt restarted.
- LOOP, pin_in tied to pin_out (sync build), div=4 → after 100 ticks err_cnt=0, err_flag=0. pin_out follows the LFSR from ACE1 (first value E1 for CH_COUNT=8).
- LOOP with pin_in[3] forced 0 → err_cnt increments on ticks where lfsr bit3=1; err_flag=1. clr_err asserted together with a mismatch → err_cnt=0.
- ERR_WIDTH=4, constant mismatch → err_cnt saturates at 15 and holds. Lowering div from 20 to 2 while cnt=10 → tick fires next cycle, then every 3 cycles.
